// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue configuration: lane widths, depth, derived pointer widths
// and the per-instruction storage entry.
package fetch_queue_pkg;

  localparam int unsigned FETCH_WIDTH       = 2;
  localparam int unsigned PIPE_WIDTH        = 2;
  localparam int unsigned FETCH_QUEUE_DEPTH = 16;
  localparam int unsigned ADDR_BITS         = 32;
  localparam int unsigned INST_BITS         = 32;

  // Pointers carry one wrap bit above the index so a full queue is distinguishable from empty.
  localparam int unsigned IDX_BITS   = $clog2(FETCH_QUEUE_DEPTH);
  localparam int unsigned PTR_BITS   = IDX_BITS + 1;
  localparam int unsigned CNT_BITS   = $clog2(FETCH_QUEUE_DEPTH + 1);
  localparam int unsigned ENQ_N_BITS = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned DEQ_N_BITS = $clog2(PIPE_WIDTH + 1);

  typedef struct packed {
    logic [ADDR_BITS-1:0] pc;
    logic [INST_BITS-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: I-cache enqueue side, decoder dequeue side, flush.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic                         flush;
  logic                         enq_val;
  logic                         enq_rdy;
  logic [ADDR_BITS-1:0]         enq_pc;
  logic [FETCH_WIDTH*INST_BITS-1:0] enq_insts;
  logic [FETCH_WIDTH-1:0]       enq_mask;
  logic [PIPE_WIDTH-1:0]        deq_val;
  logic [INST_BITS-1:0]         deq_insts [PIPE_WIDTH];
  logic [ADDR_BITS-1:0]         deq_pcs   [PIPE_WIDTH];
  logic [DEQ_N_BITS-1:0]        deq_cnt;
  logic [CNT_BITS-1:0]          count;

  modport master (
    output flush, enq_val, enq_pc, enq_insts, enq_mask, deq_cnt,
    input  enq_rdy, deq_val, deq_insts, deq_pcs, count
  );

  modport slave (
    input  flush, enq_val, enq_pc, enq_insts, enq_mask, deq_cnt,
    output enq_rdy, deq_val, deq_insts, deq_pcs, count
  );

endinterface

// File: rtl/fetch_queue_popcount.sv
// N-bit population count; sizes enqueue packets and bounds decoder dequeue counts.
module fetch_queue_popcount #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]             bits_i,
  output logic [$clog2(N+1)-1:0]   cnt_o
);

  localparam int unsigned W = $clog2(N + 1);

  // Sum the set bits.
  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Per-instruction circular queue between I-cache and decoder.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, head lanes are
// forwarded combinationally from the enqueue inputs in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  fq
);

  localparam int unsigned DEPTH = FETCH_QUEUE_DEPTH;

  logic [PTR_BITS-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_BITS-1:0]   count;
  logic [ENQ_N_BITS-1:0] enq_n;
  logic [DEQ_N_BITS-1:0] deq_pop, deq_n, deq_skip;
  logic                  enq_rdy, enq_fire, bypass;
  logic [PIPE_WIDTH-1:0] deq_val;

  fq_entry_t             mem_q  [DEPTH];
  fq_entry_t             rd_ent [PIPE_WIDTH];
  logic [FETCH_WIDTH-1:0] wr_en;
  logic [IDX_BITS-1:0]   wr_idx  [FETCH_WIDTH];
  fq_entry_t             wr_data [FETCH_WIDTH];

  fetch_queue_popcount #(.N(FETCH_WIDTH)) u_enq_pop (.bits_i(fq.enq_mask), .cnt_o(enq_n));
  fetch_queue_popcount #(.N(PIPE_WIDTH))  u_deq_pop (.bits_i(deq_val),     .cnt_o(deq_pop));

  assign count    = CNT_BITS'(wptr_q - rptr_q);
  assign enq_rdy  = ~rst & ~fq.flush & ((CNT_BITS'(DEPTH) - count) >= CNT_BITS'(FETCH_WIDTH));
  assign enq_fire = fq.enq_val & enq_rdy;

  assign fq.enq_rdy = enq_rdy;
  assign fq.count   = count;
  assign fq.deq_val = deq_val;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = enq_fire & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // Over-asks from the decoder are clamped to the lanes actually valid.
  assign deq_n    = (fq.deq_cnt > deq_pop) ? deq_pop : fq.deq_cnt;
  // Bypassed lanes consumed this cycle are never written to storage.
  assign deq_skip = bypass ? deq_n : '0;

  // Head lanes: read mux from storage, or enqueue lanes when bypassing an empty queue.
  always_comb begin
    for (int unsigned j = 0; j < PIPE_WIDTH; j++) begin
      rd_ent[j]  = mem_q[IDX_BITS'(rptr_q[IDX_BITS-1:0] + IDX_BITS'(j))];
      deq_val[j] = (j < 32'(count)) & ~fq.flush & ~rst;
      if (bypass) begin
        deq_val[j]     = (j < 32'(enq_n));
        rd_ent[j].pc   = fq.enq_pc + ADDR_BITS'(4 * j);
        rd_ent[j].inst = fq.enq_insts[j*INST_BITS +: INST_BITS];
      end
      fq.deq_pcs[j]   = deq_val[j] ? rd_ent[j].pc   : '0;
      fq.deq_insts[j] = deq_val[j] ? rd_ent[j].inst : '0;
    end
  end

  // Per-lane write enables, slots and payloads; lanes shift down past bypassed ones.
  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      wr_en[i]        = enq_fire & (i < 32'(enq_n)) & (i >= 32'(deq_skip));
      wr_idx[i]       = IDX_BITS'(wptr_q[IDX_BITS-1:0] + IDX_BITS'(i) - IDX_BITS'(deq_skip));
      wr_data[i].pc   = fq.enq_pc + ADDR_BITS'(4 * i);
      wr_data[i].inst = fq.enq_insts[i*INST_BITS +: INST_BITS];
    end
  end

  // Next pointers: enqueue and dequeue in the same cycle both take effect.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (enq_fire) wptr_d = wptr_q + PTR_BITS'(enq_n) - PTR_BITS'(deq_skip);
    if (!bypass)  rptr_d = rptr_q + PTR_BITS'(deq_n);
  end

  // Pointer state; flush discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else if (fq.flush) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  // Instruction storage; contents survive reset and flush, only pointers are cleared.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= wr_data[i];
    end
  end

  // Interface protocol checks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fq.enq_val) assert ((fq.enq_mask & (fq.enq_mask + 1'b1)) == '0);
      assert (count <= CNT_BITS'(DEPTH));
      assert ((deq_val & (deq_val + 1'b1)) == '0);
      if (!fq.flush) assert (fq.deq_cnt <= deq_pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table plus reset and bypass sequences.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_queue_if fq ();

  fetch_queue dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  typedef struct {
    logic        fl;
    logic        ev;
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [1:0]  dc;
    int          cnt;
    logic        rdy;
    logic [1:0]  dv;
    logic [31:0] p0;
    logic [31:0] p1;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return p ^ 32'hDEAD_0000;
  endfunction

  task automatic add(input logic fl, input logic ev, input logic [31:0] pc, input logic [1:0] mask,
                     input logic [1:0] dc, input int cnt, input logic rdy, input logic [1:0] dv,
                     input logic [31:0] p0, input logic [31:0] p1);
    vec_t v;
    v.fl = fl; v.ev = ev; v.pc = pc; v.mask = mask; v.dc = dc;
    v.cnt = cnt; v.rdy = rdy; v.dv = dv; v.p0 = p0; v.p1 = p1;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic fl, input logic ev, input logic [31:0] pc, input logic [1:0] mask,
                       input logic [1:0] dc);
    fq.flush     = fl;
    fq.enq_val   = ev;
    fq.enq_pc    = pc;
    fq.enq_mask  = mask;
    fq.enq_insts = {inst_of(pc + 32'd4), inst_of(pc)};
    fq.deq_cnt   = dc;
  endtask

  task automatic check_outs(input string tag, input int cnt, input logic rdy, input logic [1:0] dv,
                            input logic [31:0] p0, input logic [31:0] p1);
    logic [31:0] e0, e1;
    e0 = dv[0] ? p0 : 32'h0;
    e1 = dv[1] ? p1 : 32'h0;
    chk({tag, ".count"},   64'(fq.count),        64'(cnt));
    chk({tag, ".enq_rdy"}, 64'(fq.enq_rdy),      64'(rdy));
    chk({tag, ".deq_val"}, 64'(fq.deq_val),      64'(dv));
    chk({tag, ".pc0"},     64'(fq.deq_pcs[0]),   64'(e0));
    chk({tag, ".pc1"},     64'(fq.deq_pcs[1]),   64'(e1));
    chk({tag, ".inst0"},   64'(fq.deq_insts[0]), 64'(dv[0] ? inst_of(p0) : 32'h0));
    chk({tag, ".inst1"},   64'(fq.deq_insts[1]), 64'(dv[1] ? inst_of(p1) : 32'h0));
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 2'b00, 2'd0);
    #1 rst = 1'b1;
    #1 check_outs("reset", 0, 1'b0, 2'b00, 32'h0, 32'h0);
    #10 rst = 1'b0;

`ifndef FETCH_QUEUE_BYPASS_EN
    // Basic packet, 1-cycle latency
    add(0,0,32'h0,  2'b00,0, 0,1,2'b00,32'h0,  32'h0);
    add(0,1,32'h100,2'b11,0, 0,1,2'b00,32'h0,  32'h0);
    add(0,0,32'h0,  2'b00,0, 2,1,2'b11,32'h100,32'h104);
    add(0,0,32'h0,  2'b00,2, 2,1,2'b11,32'h100,32'h104);
    add(0,0,32'h0,  2'b00,0, 0,1,2'b00,32'h0,  32'h0);
    // Partial packet then full packet, single-lane drain
    add(0,1,32'h200,2'b01,0, 0,1,2'b00,32'h0,  32'h0);
    add(0,1,32'h300,2'b11,1, 1,1,2'b01,32'h200,32'h0);
    add(0,0,32'h0,  2'b00,1, 2,1,2'b11,32'h300,32'h304);
    add(0,0,32'h0,  2'b00,1, 1,1,2'b01,32'h304,32'h0);
    add(0,0,32'h0,  2'b00,0, 0,1,2'b00,32'h0,  32'h0);
    // Simultaneous enqueue and dequeue at count 6
    add(0,1,32'h500,2'b11,0, 0,1,2'b00,32'h0,  32'h0);
    add(0,1,32'h508,2'b11,0, 2,1,2'b11,32'h500,32'h504);
    add(0,1,32'h510,2'b11,0, 4,1,2'b11,32'h500,32'h504);
    add(0,1,32'h518,2'b11,2, 6,1,2'b11,32'h500,32'h504);
    add(0,1,32'h520,2'b11,2, 6,1,2'b11,32'h508,32'h50C);
    add(0,0,32'h0,  2'b00,2, 6,1,2'b11,32'h510,32'h514);
    add(0,0,32'h0,  2'b00,2, 4,1,2'b11,32'h518,32'h51C);
    add(0,0,32'h0,  2'b00,2, 2,1,2'b11,32'h520,32'h524);
    add(0,0,32'h0,  2'b00,0, 0,1,2'b00,32'h0,  32'h0);
    // Fill to 15, drop packet while not ready, reopen, fill to 16 across pointer wrap
    for (int k = 0; k < 7; k++)
      add(0,1,32'h600 + 32'(8*k),2'b11,0, 2*k,1,(k != 0) ? 2'b11 : 2'b00,32'h600,32'h604);
    add(0,1,32'h638,2'b01,0, 14,1,2'b11,32'h600,32'h604);
    add(0,1,32'h700,2'b11,2, 15,0,2'b11,32'h600,32'h604);
    add(0,1,32'h63C,2'b01,0, 13,1,2'b11,32'h608,32'h60C);
    add(0,1,32'h640,2'b11,0, 14,1,2'b11,32'h608,32'h60C);
    add(0,1,32'h700,2'b11,0, 16,0,2'b11,32'h608,32'h60C);
    for (int k = 0; k < 8; k++)
      add(0,0,32'h0,2'b00,2, 16 - 2*k,(k != 0),2'b11,32'h608 + 32'(8*k),32'h60C + 32'(8*k));
    add(0,0,32'h0,  2'b00,0, 0,1,2'b00,32'h0,  32'h0);
    // Flush at count 9 with a packet offered
    for (int k = 0; k < 4; k++)
      add(0,1,32'h800 + 32'(8*k),2'b11,0, 2*k,1,(k != 0) ? 2'b11 : 2'b00,32'h800,32'h804);
    add(0,1,32'h820,2'b01,0, 8,1,2'b11,32'h800,32'h804);
    add(1,1,32'h900,2'b11,0, 9,0,2'b00,32'h0,  32'h0);
    add(0,0,32'h0,  2'b00,0, 0,1,2'b00,32'h0,  32'h0);
    add(0,1,32'hA00,2'b11,0, 0,1,2'b00,32'h0,  32'h0);
    add(0,0,32'h0,  2'b00,0, 2,1,2'b11,32'hA00,32'hA04);
    add(0,0,32'h0,  2'b00,2, 2,1,2'b11,32'hA00,32'hA04);
    add(0,0,32'h0,  2'b00,0, 0,1,2'b00,32'h0,  32'h0);

    foreach (vt[i]) begin
      @(posedge clk); #1;
      drive(vt[i].fl, vt[i].ev, vt[i].pc, vt[i].mask, vt[i].dc);
      @(negedge clk);
      check_outs($sformatf("v%0d", i), vt[i].cnt, vt[i].rdy, vt[i].dv, vt[i].p0, vt[i].p1);
    end
`endif

    // Asynchronous reset mid-run with five entries held
    @(posedge clk); #1 drive(1'b0, 1'b1, 32'hB00, 2'b11, 2'd0);
    @(posedge clk); #1 drive(1'b0, 1'b1, 32'hB08, 2'b11, 2'd0);
    @(posedge clk); #1 drive(1'b0, 1'b1, 32'hB10, 2'b01, 2'd0);
    @(posedge clk); #1 drive(1'b0, 1'b0, 32'h0,   2'b00, 2'd0);
    @(negedge clk);
    check_outs("prerst", 5, 1'b1, 2'b11, 32'hB00, 32'hB04);
    #1 rst = 1'b1;
    #1 check_outs("inrst", 0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_outs("postrst", 0, 1'b1, 2'b00, 32'h0, 32'h0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Same-cycle forwarding into an empty queue, one lane consumed
    @(posedge clk); #1 drive(1'b0, 1'b1, 32'h400, 2'b11, 2'd1);
    #1 check_outs("byp0", 0, 1'b1, 2'b11, 32'h400, 32'h404);
    @(posedge clk); #1 drive(1'b0, 1'b0, 32'h0, 2'b00, 2'd0);
    @(negedge clk);
    check_outs("byp1", 1, 1'b1, 2'b01, 32'h404, 32'h0);
    @(posedge clk); #1 drive(1'b0, 1'b0, 32'h0, 2'b00, 2'd1);
    @(negedge clk);
    check_outs("byp2", 1, 1'b1, 2'b01, 32'h404, 32'h0);
    @(posedge clk); #1 drive(1'b0, 1'b0, 32'h0, 2'b00, 2'd0);
    @(negedge clk);
    check_outs("byp3", 0, 1'b1, 2'b00, 32'h0, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
